// File: rtl/paramest_nn_sdiv_31s_15ns_seq.sv
// -----------------------------------------------------------------------------
// paramest_nn_sdiv_31s_15ns_seq
//   Sequential signed-by-unsigned divider (radix-2 restoring, one quotient bit
//   per cycle). This is the inverse of the NN datapath's 16s x 15ns -> 31
//   multiply: it brings accumulated products back to layer precision.
//   Quotient truncates toward zero and the remainder takes the dividend's sign.
//
//   Ports:
//     ap_clk, ap_rst_n      clock (rising edge), async active-low reset
//     in_valid / in_ready   operand handshake; in_ready is high only when idle
//     din0                  signed dividend   (din0_WIDTH bits)
//     din1                  unsigned divisor  (din1_WIDTH bits)
//     out_valid / out_ready result handshake; result held until accepted
//     quot                  signed quotient   (dout_WIDTH bits)
//     rem                   signed remainder  (din1_WIDTH+1 bits)
//     q_ovf                 true quotient outside the signed dout_WIDTH range
//     div_zero              divisor was zero
//
//   Build option:
//     PARAMEST_DIV_SAT_EN   defined: an overflowing quotient saturates to the
//                           signed limit of its true sign.
//                           undefined: quotient wraps to its low dout_WIDTH bits.
// -----------------------------------------------------------------------------
module paramest_nn_sdiv_31s_15ns_seq #(
  parameter int unsigned din0_WIDTH = 31,
  parameter int unsigned din1_WIDTH = 15,
  parameter int unsigned dout_WIDTH = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] quot,
  output logic [din1_WIDTH:0]   rem,
  output logic                  q_ovf,
  output logic                  div_zero
);

  localparam int unsigned QW = din0_WIDTH;
  localparam int unsigned DW = din1_WIDTH;
  localparam int unsigned OW = dout_WIDTH;
  localparam int unsigned RW = din1_WIDTH + 1;
  localparam int unsigned CW = (din0_WIDTH > 1) ? $clog2(din0_WIDTH) : 1;
  // Upper magnitude bits that must be clear for the quotient to fit OW signed
  localparam int unsigned HW = QW - OW + 1;

  localparam logic [OW-1:0] Q_MAX = {1'b0, {(OW-1){1'b1}}};
  localparam logic [OW-1:0] Q_MIN = {1'b1, {(OW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e          state_q,     state_d;
  logic [CW-1:0]   cnt_q,       cnt_d;
  logic [DW-1:0]   div_q,       div_d;
  logic            neg_q,       neg_d;
  logic [QW-1:0]   acc_q,       acc_d;
  logic [DW-1:0]   prem_q,      prem_d;
  logic [OW-1:0]   quot_q,      quot_d;
  logic [RW-1:0]   rem_q,       rem_d;
  logic            q_ovf_q,     q_ovf_d;
  logic            div_zero_q,  div_zero_d;
  logic            out_valid_q, out_valid_d;
  logic            in_ready_q,  in_ready_d;

  // Datapath intermediates
  logic [DW:0]     trial;
  logic            ge;
  logic [QW-1:0]   din0_mag;
  logic [HW-1:0]   q_hi;
  logic            ovf_pos;
  logic            ovf_neg;
  logic            ovf;
  logic [OW-1:0]   q_wrap;
  logic [RW-1:0]   rem_signed;

  // Magnitude of the incoming dividend; -2^(QW-1) maps to 2^(QW-1) unsigned
  always_comb begin
    din0_mag = din0;
    if (din0[QW-1]) begin
      din0_mag = ~din0 + QW'(1);
    end
  end

  // One restoring step: shift the next dividend bit into the partial remainder
  always_comb begin
    trial = {prem_q, acc_q[QW-1]};
    ge    = (trial >= {1'b0, div_q});
  end

  // Sign, overflow and remainder fix-up from the finished magnitude quotient
  always_comb begin
    q_hi    = acc_q[QW-1:OW-1];
    ovf_pos = |q_hi;
    // Negative side tolerates exactly 2^(OW-1)
    ovf_neg = (|q_hi) && !((q_hi == HW'(1)) && (acc_q[OW-2:0] == '0));
    ovf     = neg_q ? ovf_neg : ovf_pos;
    q_wrap  = neg_q ? (~acc_q[OW-1:0] + OW'(1)) : acc_q[OW-1:0];
    rem_signed = neg_q ? (~{1'b0, prem_q} + RW'(1)) : {1'b0, prem_q};
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    neg_d       = neg_q;
    acc_d       = acc_q;
    prem_d      = prem_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    q_ovf_d     = q_ovf_q;
    div_zero_d  = div_zero_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d = S_CALC;
          cnt_d   = CW'(QW - 1);
          div_d   = din1;
          neg_d   = din0[QW-1];
          acc_d   = din0_mag;
          prem_d  = '0;
        end
      end

      S_CALC: begin
        // acc shifts dividend bits out of the top and quotient bits in below
        acc_d  = {acc_q[QW-2:0], ge};
        prem_d = ge ? (trial[DW-1:0] - div_q) : trial[DW-1:0];
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        state_d = S_DONE;
        if (div_q == '0) begin
          // Full-length CALC still ran so latency stays fixed; result forced
          div_zero_d = 1'b1;
          q_ovf_d    = 1'b0;
          rem_d      = '0;
          quot_d     = neg_q ? Q_MIN : Q_MAX;
        end else begin
          div_zero_d = 1'b0;
          q_ovf_d    = ovf;
          rem_d      = rem_signed;
`ifdef PARAMEST_DIV_SAT_EN
          quot_d     = ovf ? (neg_q ? Q_MIN : Q_MAX) : q_wrap;
`else
          quot_d     = q_wrap;
`endif
        end
      end

      S_DONE: begin
        // out_valid is registered off DONE, so it rises one cycle after entry
        if (out_valid_q) begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
          end
        end else begin
          out_valid_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    in_ready_d = (state_d == S_IDLE);
  end

  // State and datapath registers
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      div_q       <= '0;
      neg_q       <= 1'b0;
      acc_q       <= '0;
      prem_q      <= '0;
      quot_q      <= '0;
      rem_q       <= '0;
      q_ovf_q     <= 1'b0;
      div_zero_q  <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      neg_q       <= neg_d;
      acc_q       <= acc_d;
      prem_q      <= prem_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      q_ovf_q     <= q_ovf_d;
      div_zero_q  <= div_zero_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign quot      = quot_q;
  assign rem       = rem_q;
  assign q_ovf     = q_ovf_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_paramest_nn_sdiv_31s_15ns_seq.sv
// -----------------------------------------------------------------------------
// tb_paramest_nn_sdiv_31s_15ns_seq
//   Bench for the sequential signed divider: directed corner cases, handshake
//   stall, mid-operation reset and random operands, all compared against a
//   plain-arithmetic C-style division model.
// -----------------------------------------------------------------------------
module tb_paramest_nn_sdiv_31s_15ns_seq;

  logic        ap_clk;
  logic        ap_rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [30:0] din0;
  logic [14:0] din1;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quot;
  logic [15:0] rem;
  logic        q_ovf;
  logic        div_zero;

  int total;
  int bad;

  paramest_nn_sdiv_31s_15ns_seq dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din0      (din0),
    .din1      (din1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quot      (quot),
    .rem       (rem),
    .q_ovf     (q_ovf),
    .div_zero  (div_zero)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: C-style truncating division on wide integers
  task automatic model(input logic signed [30:0] a, input logic [14:0] b,
                       output logic [15:0] eq, output logic [15:0] er,
                       output logic eovf, output logic edz);
    longint la;
    longint lb;
    longint q;
    longint r;
    la = a;
    lb = longint'(b);
    if (lb == 0) begin
      edz  = 1'b1;
      eovf = 1'b0;
      er   = 16'h0000;
      eq   = (la >= 0) ? 16'h7FFF : 16'h8000;
    end else begin
      q    = la / lb;
      r    = la % lb;
      edz  = 1'b0;
      eovf = (q > 32767) || (q < -32768);
      er   = 16'(r);
`ifdef PARAMEST_DIV_SAT_EN
      eq   = eovf ? ((q < 0) ? 16'h8000 : 16'h7FFF) : 16'(q);
`else
      eq   = 16'(q);
`endif
    end
  endtask

  // One full transaction with optional output stall
  task automatic run(input logic signed [30:0] a, input logic [14:0] b, input int stall);
    logic [15:0] eq;
    logic [15:0] er;
    logic        eovf;
    logic        edz;
    int          cyc;
    int          w;
    model(a, b, eq, er, eovf, edz);

    w = 0;
    @(negedge ap_clk);
    while (!in_ready && w < 50) begin
      @(negedge ap_clk);
      w++;
    end
    chk("in_ready_before_op", 64'(in_ready), 64'd1);

    din0     = a;
    din1     = b;
    in_valid = 1'b1;
    @(posedge ap_clk);
    #1;
    in_valid = 1'b0;
    chk("in_ready_low_after_accept", 64'(in_ready), 64'd0);

    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge ap_clk);
      #1;
      cyc++;
    end
    chk("latency", 64'(cyc), 64'd33);
    chk("quot", 64'(quot), 64'(eq));
    chk("rem", 64'(rem), 64'(er));
    chk("q_ovf", 64'(q_ovf), 64'(eovf));
    chk("div_zero", 64'(div_zero), 64'(edz));

    for (int s = 0; s < stall; s++) begin
      @(negedge ap_clk);
      din0     = 31'd77;
      din1     = 15'd3;
      in_valid = 1'b1;
      @(posedge ap_clk);
      #1;
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_quot", 64'(quot), 64'(eq));
      chk("stall_rem", 64'(rem), 64'(er));
      chk("stall_flags", 64'({q_ovf, div_zero}), 64'({eovf, edz}));
    end

    @(negedge ap_clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge ap_clk);
    #1;
    chk("handshake_out_valid_low", 64'(out_valid), 64'd0);
    chk("handshake_in_ready_high", 64'(in_ready), 64'd1);
    @(negedge ap_clk);
    out_ready = 1'b0;
  endtask

  initial begin
    logic signed [30:0] ra;
    logic [14:0]        rb;
    total     = 0;
    bad       = 0;
    ap_rst_n  = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    din0      = '0;
    din1      = '0;

    repeat (3) @(posedge ap_clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_quot", 64'(quot), 64'd0);
    chk("rst_rem", 64'(rem), 64'd0);
    chk("rst_flags", 64'({q_ovf, div_zero}), 64'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    // Directed corners
    run(31'sd1000, 15'd7, 0);
    run(-31'sd1000, 15'd7, 0);
    run(31'h4000_0000, 15'd1, 0);          // -2^30
    run(31'h3FFF_FFFF, 15'd1, 0);          // 2^30-1
    run(31'sd32767, 15'd1, 0);
    run(-31'sd32768, 15'd1, 0);
    run(-31'sd32769, 15'd1, 0);
    run(31'sd32768, 15'd1, 0);
    run(31'sd5, 15'd0, 0);
    run(-31'sd5, 15'd0, 0);
    run(31'sd6, 15'h7FFF, 0);
    run(31'sd12345678, 15'd999, 5);        // output stall with in_valid pressure

    // Reset during CALC
    @(negedge ap_clk);
    din0     = 31'sd12345;
    din1     = 15'd17;
    in_valid = 1'b1;
    @(posedge ap_clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    chk("midreset_in_ready", 64'(in_ready), 64'd1);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    run(31'sd100, 15'd3, 0);

    // Random operands
    for (int i = 0; i < 24; i++) begin
      ra = 31'($urandom);
      if (i % 3 == 0) ra = 31'($signed(16'($urandom)));
      rb = 15'($urandom);
      if (i % 2 == 0) rb = 15'($urandom_range(1, 255));
      if (i % 7 == 3) rb = 15'd0;
      run(ra, rb, (i % 5 == 1) ? 2 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
